// File: rtl/rule90_pkg.sv
// Shared definitions for the Rule-90 run controller.
// Contents:
//   WIDTH, GEN_W : default cell count and generation-counter width
//   state_t      : controller FSM states (IDLE, LOAD, RUN, DONE)
//   cells_t      : one full automaton state at the default WIDTH
package rule90_pkg;

    localparam int WIDTH = 512;
    localparam int GEN_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [WIDTH-1:0] cells_t;

endpackage

// File: rtl/rule90_run_ctrl_if.sv
// Seed-producer / result-consumer bundle of the Rule-90 run controller.
// Signals:
//   seed_valid/seed_ready/seed_data/seed_gens : seed request channel
//   abort                                      : cancel the current job
//   res_valid/res_ready/res_data/res_gens/res_early : snapshot channel
//   busy                                       : controller not idle
// Modports: master = producer/consumer side, slave = controller side.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both 1. The controller never lowers res_valid
// or changes res_* before that transfer (abort excepted), and seed_ready
// depends only on the controller state, never on seed_valid.
interface rule90_run_ctrl_if #(
    parameter int WIDTH = rule90_pkg::WIDTH,
    parameter int GEN_W = rule90_pkg::GEN_W
);
    logic             seed_valid;
    logic             seed_ready;
    logic [WIDTH-1:0] seed_data;
    logic [GEN_W-1:0] seed_gens;
    logic             abort;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [GEN_W-1:0] res_gens;
    logic             res_early;
    logic             busy;

    modport master (
        output seed_valid, seed_data, seed_gens, abort, res_ready,
        input  seed_ready, res_valid, res_data, res_gens, res_early, busy
    );

    modport slave (
        input  seed_valid, seed_data, seed_gens, abort, res_ready,
        output seed_ready, res_valid, res_data, res_gens, res_early, busy
    );
endinterface

// File: rtl/rule90_ca.sv
// WIDTH-cell Rule-90 automaton with null (zero) boundaries.
// Each cell's next value is the XOR of its two neighbours; cells beyond
// either end read as 0. Loads data_i when load_i is high, otherwise
// advances one generation every clock.
// Ports:
//   clk, rst_n : clock, asynchronous active-low clear
//   load_i     : load strobe
//   data_i     : load value
//   q_o        : current generation
module rule90_ca #(
    parameter int WIDTH = rule90_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] cells_q;
    logic [WIDTH-1:0] cells_d;

    always_comb begin
        cells_d = cells_q;
        if (load_i) begin
            cells_d = data_i;
        end else begin
            // Shifting in zeros on both sides gives the null boundary.
            cells_d = {cells_q[WIDTH-2:0], 1'b0} ^ {1'b0, cells_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cells_q <= '0;
        end else begin
            cells_q <= cells_d;
        end
    end

    assign q_o = cells_q;

endmodule

// File: rtl/rule90_snap_reg.sv
// Snapshot register: holds the captured cell state, the generation count
// that produced it and the early-stop flag.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low clear
//   cap_en_i     : load the three capture inputs this edge
//   cap_data_i   : cell state to capture
//   cap_gens_i   : generation count to capture
//   cap_early_i  : early-stop flag to capture
//   snap_*_o     : current register contents
module rule90_snap_reg
    import rule90_pkg::*;
#(
    parameter int WIDTH = rule90_pkg::WIDTH,
    parameter int GEN_W = rule90_pkg::GEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_en_i,
    input  logic [WIDTH-1:0] cap_data_i,
    input  logic [GEN_W-1:0] cap_gens_i,
    input  logic             cap_early_i,
    output logic [WIDTH-1:0] snap_data_o,
    output logic [GEN_W-1:0] snap_gens_o,
    output logic             snap_early_o
);

    localparam int SNAP_W = WIDTH + GEN_W + 1;

    logic [SNAP_W-1:0] snap_q;
    logic [SNAP_W-1:0] snap_d;

    always_comb begin
        snap_d = snap_q;
        if (cap_en_i) begin
            snap_d = {cap_early_i, cap_gens_i, cap_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign snap_data_o  = snap_q[WIDTH-1:0];
    assign snap_gens_o  = snap_q[WIDTH +: GEN_W];
    assign snap_early_o = snap_q[SNAP_W-1];

endmodule

// File: rtl/rule90_run_ctrl.sv
// Rule-90 run controller: accepts a seed and a generation count, loads an
// external automaton, counts generations while it evolves, and snapshots
// the state when the requested count is reached.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : rule90_run_ctrl_if.slave (seed / abort / result channels)
//   ca_load     : automaton load strobe (high for exactly the LOAD cycle)
//   ca_data     : automaton load data (registered seed)
//   ca_q        : automaton current state
//   dbg_state_o : current FSM state
// Build option: define RULE90_EARLY_STOP_EN to end a run as soon as the
// automaton reaches the all-zero state (a Rule-90 fixed point); otherwise
// res_early is always 0 and every run lasts the full generation count.
module rule90_run_ctrl
    import rule90_pkg::*;
#(
    parameter int WIDTH = rule90_pkg::WIDTH,
    parameter int GEN_W = rule90_pkg::GEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    rule90_run_ctrl_if.slave bus,
    output logic             ca_load,
    output logic [WIDTH-1:0] ca_data,
    input  logic [WIDTH-1:0] ca_q,
    output state_t           dbg_state_o
);

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] ca_data_q;
    logic [WIDTH-1:0] ca_data_d;
    logic [GEN_W-1:0] tgt_q;
    logic [GEN_W-1:0] tgt_d;
    logic [GEN_W-1:0] gen_cnt_q;
    logic [GEN_W-1:0] gen_cnt_d;

    logic gen_hit;
    logic early_hit;
    logic run_end;
    logic cap_en;

    // In RUN, ca_q holds generation gen_cnt_q.
    assign gen_hit = (gen_cnt_q == tgt_q);

`ifdef RULE90_EARLY_STOP_EN
    assign early_hit = (ca_q == '0) && (gen_cnt_q < tgt_q);
`else
    assign early_hit = 1'b0;
`endif

    assign run_end = gen_hit || early_hit;

    // abort wins over the capture: an aborted job leaves the snapshot alone.
    assign cap_en = (state_q == RUN) && run_end && !bus.abort;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.seed_valid) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN:  if (run_end) state_d = DONE;
            DONE: if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // abort overrides every transition except in IDLE, where it is ignored.
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // ---------------- FSM: outputs (decoded from state only) ----------------
    always_comb begin
        bus.seed_ready = (state_q == IDLE);
        bus.busy       = (state_q != IDLE);
        bus.res_valid  = (state_q == DONE);
        ca_load        = (state_q == LOAD);
    end

    assign dbg_state_o = state_q;

    // ---------------- Job datapath ----------------
    always_comb begin
        ca_data_d = ca_data_q;
        tgt_d     = tgt_q;
        gen_cnt_d = gen_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.seed_valid) begin
                    ca_data_d = bus.seed_data;
                    tgt_d     = bus.seed_gens;
                end
            end
            LOAD: gen_cnt_d = '0;
            RUN: begin
                // Never wraps: the increment only happens while gen_cnt_q < tgt_q.
                if (!run_end && !bus.abort) begin
                    gen_cnt_d = gen_cnt_q + GEN_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca_data_q <= '0;
            tgt_q     <= '0;
            gen_cnt_q <= '0;
        end else begin
            ca_data_q <= ca_data_d;
            tgt_q     <= tgt_d;
            gen_cnt_q <= gen_cnt_d;
        end
    end

    assign ca_data = ca_data_q;

    // ---------------- Snapshot ----------------
    rule90_snap_reg #(
        .WIDTH (WIDTH),
        .GEN_W (GEN_W)
    ) u_snap (
        .clk          (clk),
        .rst_n        (rst_n),
        .cap_en_i     (cap_en),
        .cap_data_i   (ca_q),
        .cap_gens_i   (gen_cnt_q),
        .cap_early_i  (early_hit),
        .snap_data_o  (bus.res_data),
        .snap_gens_o  (bus.res_gens),
        .snap_early_o (bus.res_early)
    );

endmodule
